// File: rtl/uart_pkg.sv
// Purpose: shared UART constants and the transmit pacing state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_WIDTH default, frame bit counts, derived FRAME_CYCLES, tx_state_t.
package uart_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int START_BITS   = 1;
  localparam int STOP_BITS    = 1;
  localparam int IDLE_BITS    = 1;
  // One frame on tx_out: start + data + stop + one idle bit time.
  localparam int FRAME_CYCLES = START_BITS + DATA_WIDTH + STOP_BITS + IDLE_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose: single-clock circular-buffer FIFO with explicit occupancy counter.
// Latency: a pushed entry is visible on rd_data the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, rst_n (sync, active-low); wr_data/wr_en push side;
//        rd_en pop, rd_data head entry; level occupancy; full, empty flags.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DEPTH      = 8,
  localparam int PW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  push;
  logic                  pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Purpose: buffers host bytes and issues them to the transmitter one frame apart.
// Latency: byte written into an empty idle feeder pulses enable after the following edge.
// Backpressure: wr_ready drops while the FIFO is full or in reset; writes are never dropped.
// Ports: tx_clk, rst_n (sync, active-low); wr_data/wr_valid/wr_ready host side;
//        data_source/enable to transmitter (registered); level occupancy; busy activity flag.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = uart_pkg::DATA_WIDTH,
  parameter int DEPTH        = 8,
  parameter int FRAME_CYCLES = uart_pkg::FRAME_CYCLES,
  localparam int LW          = $clog2(DEPTH + 1),
  localparam int GW          = $clog2(FRAME_CYCLES)
) (
  input  logic                  tx_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] data_source,
  output logic                  enable,
  output logic [LW-1:0]         level,
  output logic                  busy
);

  tx_state_t             state;
  tx_state_t             state_nxt;
  logic [GW-1:0]         gap_cnt;
  logic [GW-1:0]         gap_nxt;
  logic                  enable_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  pop;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  // wr_ready reflects occupancy before this edge's pop, so a full FIFO
  // refuses a write even on the edge that frees a slot.
  assign wr_ready = rst_n && !fifo_full;
  assign wr_en    = wr_valid && wr_ready;
  assign busy     = (state == GAP) || !fifo_empty;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (tx_clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge tx_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      enable      <= 1'b0;
      data_source <= '0;
    end else begin
      state       <= state_nxt;
      gap_cnt     <= gap_nxt;
      enable      <= enable_nxt;
      data_source <= data_nxt;
    end
  end

  // Issue edge loads FRAME_CYCLES-1; leaving GAP when the count reads 1
  // makes the next issue edge land exactly FRAME_CYCLES edges later.
  always_comb begin
    state_nxt  = state;
    gap_nxt    = gap_cnt;
    enable_nxt = 1'b0;
    data_nxt   = data_source;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          data_nxt   = fifo_rd_data;
          enable_nxt = 1'b1;
          pop        = 1'b1;
          gap_nxt    = GW'(FRAME_CYCLES - 1);
          state_nxt  = GAP;
        end
      end
      GAP: begin
        gap_nxt = gap_cnt - GW'(1);
        if (gap_cnt == GW'(1)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
